// File: rtl/switch_debouncer_debounce_bit.sv
// Debounces one raw switch/button: synchronizer, stability counter, level register
// and the rise/fall/toggle flags that hang off the accepted level.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_toggle
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_toggle;

    // Plain shift chain into the clock domain; the last stage is the only one used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
    // any sample matching the current level, even on the terminal cycle, aborts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_STABLE;
            r_count  <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= r_toggle ^ r_rise;
            case (r_state)
                ST_STABLE: begin
                    r_count <= '0;
                    if (w_sync != r_level) begin
                        r_state <= ST_CHANGING;
                        r_count <= CW'(1);
                    end
                end
                ST_CHANGING: begin
                    if (w_sync == r_level) begin
                        r_state <= ST_STABLE;
                        r_count <= '0;
                    end else if (r_count == TERM_COUNT) begin
                        r_state <= ST_STABLE;
                        r_count <= '0;
                        r_level <= w_sync;
                        r_rise  <= w_sync;
                        r_fall  <= ~w_sync;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign sw_level  = r_level;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;
    assign sw_toggle = r_toggle;

endmodule

// File: rtl/switch_debouncer.sv
// Board-input front end: one independent debouncer per switch/button bit.
module switch_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] sw_toggle
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_debounce_bit (
            .clk      (clk),
            .rst      (rst),
            .sw_raw   (sw_raw[g]),
            .sw_level (sw_level[g]),
            .sw_rise  (sw_rise[g]),
            .sw_fall  (sw_fall[g]),
            .sw_toggle(sw_toggle[g])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, WIDTH=4.
module tb_switch_debouncer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_level;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] sw_toggle;

    int errorCount = 0;
    int checkCount = 0;
    int riseCnt [WIDTH];
    int fallCnt [WIDTH];
    int bothCnt = 0;
    int riseSnap[WIDTH];
    int fallSnap[WIDTH];

    switch_debouncer #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(8),
        .SYNC_STAGES    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_level (sw_level),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_toggle(sw_toggle)
    );

    always #5 clk = ~clk;

    // Counts every cycle a pulse is high, so a wide pulse shows up as an extra count.
    initial begin
        for (int i = 0; i < WIDTH; i++) begin
            riseCnt[i] = 0;
            fallCnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < WIDTH; i++) begin
                if (sw_rise[i]) riseCnt[i]++;
                if (sw_fall[i]) fallCnt[i]++;
                if (sw_rise[i] && sw_fall[i]) bothCnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snapCounts();
        for (int i = 0; i < WIDTH; i++) begin
            riseSnap[i] = riseCnt[i];
            fallSnap[i] = fallCnt[i];
        end
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = 4'b0000;

        // 1: reset and quiet period
        applyStimulus(5);
        rst = 1'b0;
        checkOutput("reset_level", 32'(sw_level), 32'h0);
        checkOutput("reset_rise", 32'(sw_rise), 32'h0);
        checkOutput("reset_fall", 32'(sw_fall), 32'h0);
        checkOutput("reset_toggle", 32'(sw_toggle), 32'h0);
        snapCounts();
        applyStimulus(50);
        checkOutput("quiet_level", 32'(sw_level), 32'h0);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput($sformatf("quiet_rise%0d", i), 32'(riseCnt[i] - riseSnap[i]), 32'd0);
            checkOutput($sformatf("quiet_fall%0d", i), 32'(fallCnt[i] - fallSnap[i]), 32'd0);
        end

        // 2: clean step on bit 0, level changes exactly 10 edges later
        sw_raw[0] = 1'b1;
        applyStimulus(9);
        checkOutput("step_pre_level", 32'(sw_level), 32'h0);
        checkOutput("step_pre_rise", 32'(sw_rise), 32'h0);
        applyStimulus(1);
        checkOutput("step_level", 32'(sw_level), 32'h1);
        checkOutput("step_rise", 32'(sw_rise), 32'h1);
        checkOutput("step_fall", 32'(sw_fall), 32'h0);
        checkOutput("step_toggle_same", 32'(sw_toggle), 32'h0);
        applyStimulus(1);
        checkOutput("step_rise_end", 32'(sw_rise), 32'h0);
        checkOutput("step_toggle", 32'(sw_toggle), 32'h1);
        applyStimulus(5);

        // 3: bit 1 bounces every 3 cycles, then settles high
        snapCounts();
        for (int k = 0; k < 10; k++) begin
            sw_raw[1] = (k % 2 == 0);
            applyStimulus(3);
        end
        sw_raw[1] = 1'b1;
        checkOutput("bounce_norise", 32'(riseCnt[1] - riseSnap[1]), 32'd0);
        checkOutput("bounce_nofall", 32'(fallCnt[1] - fallSnap[1]), 32'd0);
        applyStimulus(9);
        checkOutput("bounce_pre_level", 32'(sw_level), 32'h1);
        applyStimulus(1);
        checkOutput("bounce_level", 32'(sw_level), 32'h3);
        checkOutput("bounce_rise", 32'(sw_rise), 32'h2);
        applyStimulus(1);
        checkOutput("bounce_toggle", 32'(sw_toggle), 32'h3);
        applyStimulus(3);
        checkOutput("bounce_rise_count", 32'(riseCnt[1] - riseSnap[1]), 32'd1);

        // 4: seven-cycle glitch on bit 2 is one sample short of acceptance
        snapCounts();
        sw_raw[2] = 1'b1;
        applyStimulus(7);
        sw_raw[2] = 1'b0;
        applyStimulus(30);
        checkOutput("glitch_level", 32'(sw_level), 32'h3);
        checkOutput("glitch_rise", 32'(riseCnt[2] - riseSnap[2]), 32'd0);
        checkOutput("glitch_fall", 32'(fallCnt[2] - fallSnap[2]), 32'd0);

        // 5: two press/release cycles on bit 3
        snapCounts();
        for (int p = 0; p < 2; p++) begin
            sw_raw[3] = 1'b1;
            applyStimulus(10);
            checkOutput($sformatf("press%0d_rise", p), 32'(sw_rise), 32'h8);
            checkOutput($sformatf("press%0d_level", p), 32'(sw_level), 32'hB);
            applyStimulus(1);
            checkOutput($sformatf("press%0d_toggle", p), 32'(sw_toggle[3]), (p == 0) ? 32'd1 : 32'd0);
            applyStimulus(9);
            sw_raw[3] = 1'b0;
            applyStimulus(10);
            checkOutput($sformatf("release%0d_fall", p), 32'(sw_fall), 32'h8);
            checkOutput($sformatf("release%0d_level", p), 32'(sw_level), 32'h3);
            applyStimulus(10);
        end
        checkOutput("press_rise_count", 32'(riseCnt[3] - riseSnap[3]), 32'd2);
        checkOutput("press_fall_count", 32'(fallCnt[3] - fallSnap[3]), 32'd2);

        // 6: reset five cycles into a count on bit 0
        sw_raw[0] = 1'b0;
        applyStimulus(10);
        checkOutput("pre_reset_fall", 32'(sw_fall), 32'h1);
        applyStimulus(5);
        snapCounts();
        sw_raw[0] = 1'b1;
        applyStimulus(7);
        rst = 1'b1;
        applyStimulus(3);
        rst = 1'b0;
        checkOutput("midreset_level", 32'(sw_level), 32'h0);
        checkOutput("midreset_toggle", 32'(sw_toggle), 32'h0);
        checkOutput("midreset_norise", 32'(riseCnt[0] - riseSnap[0]), 32'd0);
        applyStimulus(9);
        checkOutput("after_reset_pre", 32'(sw_level), 32'h0);
        applyStimulus(1);
        checkOutput("after_reset_rise", 32'(sw_rise), 32'h3);
        checkOutput("after_reset_level", 32'(sw_level), 32'h3);
        applyStimulus(1);
        checkOutput("after_reset_toggle", 32'(sw_toggle), 32'h3);
        applyStimulus(3);
        checkOutput("both_pulses", 32'(bothCnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
